// File: rtl/priority_tagger.sv
// priority_tagger: merges an HP and an NP valid/ready channel into one tagged
// stream with a starvation-limited fixed-priority arbiter. Stats: PRIO_TAGGER_STATS_EN.
module priority_tagger #(
  parameter int DW           = 33,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-2:0] hp_data_in,
  input  logic          hp_vld_i,
  output logic          hp_rdy_o,
  input  logic [DW-2:0] np_data_in,
  input  logic          np_vld_i,
  output logic          np_rdy_o,
  output logic [DW-1:0] data_out,
  output logic          vld_o,
  input  logic          rdy_i
`ifdef PRIO_TAGGER_STATS_EN
  ,
  output logic [15:0]   hp_cnt,
  output logic [15:0]   np_cnt
`endif
);

  localparam logic [7:0] LIM = 8'(STARVE_LIMIT);

  logic [DW-1:0] r_data;
  logic          r_vld;
  logic [7:0]    r_cnt;
  logic [7:0]    w_cnt_nxt;
  logic          w_load_en;
  logic          w_hp_win;
  logic          w_grant_hp;
  logic          w_grant_np;

  assign w_load_en  = !r_vld | rdy_i;
  // HP wins unless NP is waiting and the HP streak has hit the limit
  assign w_hp_win   = hp_vld_i & (!np_vld_i | (r_cnt < LIM));
  assign w_grant_hp = w_load_en & w_hp_win;
  assign w_grant_np = w_load_en & np_vld_i & !w_hp_win;

  assign hp_rdy_o = rst & w_grant_hp;
  assign np_rdy_o = rst & w_grant_np;
  assign data_out = r_data;
  assign vld_o    = r_vld;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (!np_vld_i || w_grant_np)
      w_cnt_nxt = 8'd0;
    else if (w_grant_hp)
      w_cnt_nxt = r_cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld  <= 1'b0;
      r_data <= '0;
      r_cnt  <= 8'd0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_load_en) begin
        r_vld <= w_grant_hp | w_grant_np;
        if (w_grant_hp)
          r_data <= {1'b1, hp_data_in};
        else if (w_grant_np)
          r_data <= {1'b0, np_data_in};
      end
    end
  end

`ifdef PRIO_TAGGER_STATS_EN
  logic [15:0] r_hp_cnt;
  logic [15:0] r_np_cnt;
  logic        w_xfer;

  assign w_xfer = r_vld & rdy_i;
  assign hp_cnt = r_hp_cnt;
  assign np_cnt = r_np_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hp_cnt <= 16'd0;
      r_np_cnt <= 16'd0;
    end else if (w_xfer) begin
      if (r_data[DW-1] && r_hp_cnt != 16'hFFFF)
        r_hp_cnt <= r_hp_cnt + 16'd1;
      if (!r_data[DW-1] && r_np_cnt != 16'hFFFF)
        r_np_cnt <= r_np_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_priority_tagger.sv
// tb_priority_tagger: directed stimulus with a queue scoreboard and a
// separate output monitor for priority_tagger.
module tb_priority_tagger;

  localparam int DW = 33;

  logic          clk;
  logic          rst;
  logic [DW-2:0] hp_data_in;
  logic          hp_vld_i;
  logic          hp_rdy_o;
  logic [DW-2:0] np_data_in;
  logic          np_vld_i;
  logic          np_rdy_o;
  logic [DW-1:0] data_out;
  logic          vld_o;
  logic          rdy_i;
`ifdef PRIO_TAGGER_STATS_EN
  logic [15:0]   hp_cnt;
  logic [15:0]   np_cnt;
`endif

  priority_tagger #(.DW(DW), .STARVE_LIMIT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .hp_data_in (hp_data_in),
    .hp_vld_i   (hp_vld_i),
    .hp_rdy_o   (hp_rdy_o),
    .np_data_in (np_data_in),
    .np_vld_i   (np_vld_i),
    .np_rdy_o   (np_rdy_o),
    .data_out   (data_out),
    .vld_o      (vld_o),
    .rdy_i      (rdy_i)
`ifdef PRIO_TAGGER_STATS_EN
    ,
    .hp_cnt     (hp_cnt),
    .np_cnt     (np_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [DW-1:0] sb[$];
  logic          tags[$];
  int            np_acc[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // Accepted input words become expected outputs in acceptance order
  always @(negedge clk) begin
    if (rst) begin
      if (hp_vld_i && hp_rdy_o) sb.push_back({1'b1, hp_data_in});
      if (np_vld_i && np_rdy_o) sb.push_back({1'b0, np_data_in});
    end
  end

  // Monitor: every output transfer must match the oldest expected word
  always @(negedge clk) begin
    if (rst && vld_o && rdy_i) begin
      if (sb.size() == 0) chk("sb_unexpected", {31'd0, data_out}, 64'hFFFF);
      else chk("sb_word", {31'd0, data_out}, {31'd0, sb.pop_front()});
      tags.push_back(data_out[DW-1]);
    end
  end

  // mode 0: rdy=1, 1: random rdy, 2: stall cycles 6..9, 3: rdy=0
  task automatic stream(input int nh, input int nn, input logic [31:0] hb,
                        input logic [31:0] nb, input int mode,
                        input int max_cyc);
    int hi;
    int ni;
    int cyc;
    bit ha;
    bit na;
    hi = 0;
    ni = 0;
    cyc = 0;
    hp_vld_i = (nh > 0);
    hp_data_in = hb;
    np_vld_i = (nn > 0);
    np_data_in = nb;
    while ((hi < nh || ni < nn) && cyc < max_cyc) begin
      case (mode)
        0: rdy_i = 1'b1;
        1: rdy_i = ($urandom_range(0, 3) != 0);
        2: rdy_i = !(cyc >= 6 && cyc <= 9);
        default: rdy_i = 1'b0;
      endcase
      @(negedge clk);
      ha = hp_vld_i & hp_rdy_o;
      na = np_vld_i & np_rdy_o;
      if (na) np_acc.push_back(cyc);
      if (mode == 2 && !rdy_i) begin
        chk("bp_hp_rdy", {63'd0, hp_rdy_o}, 64'd0);
        chk("bp_np_rdy", {63'd0, np_rdy_o}, 64'd0);
        chk("bp_vld", {63'd0, vld_o}, 64'd1);
        chk("bp_hold", {31'd0, data_out},
            sb.size() > 0 ? {31'd0, sb[0]} : 64'hDEAD);
      end
      @(posedge clk);
      #1;
      if (ha) begin
        hi++;
        hp_data_in = hb + 32'(hi);
        hp_vld_i = (hi < nh);
      end
      if (na) begin
        ni++;
        np_data_in = nb + 32'(ni);
        np_vld_i = (ni < nn);
      end
      cyc++;
    end
    chk("stream_accepted", 64'(hi + ni), 64'(nh + nn));
    hp_vld_i = 1'b0;
    np_vld_i = 1'b0;
  endtask

  task automatic drain();
    rdy_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #1;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic chk_tags(input string nm, input int n);
    chk(nm, 64'(tags.size()), 64'(n));
    for (int k = 0; k < n && k < tags.size(); k++)
      chk(nm, {63'd0, tags[k]}, {63'd0, (k % 5) != 4});
  endtask

  initial begin
    rst = 1'b1;
    rdy_i = 1'b1;
    hp_vld_i = 1'b1;
    np_vld_i = 1'b1;
    hp_data_in = 32'hAAAA0001;
    np_data_in = 32'hBBBB0001;
    #2 rst = 1'b0;

    repeat (3) begin
      @(negedge clk);
      chk("rst_vld", {63'd0, vld_o}, 64'd0);
      chk("rst_data", {31'd0, data_out}, 64'd0);
      chk("rst_hp_rdy", {63'd0, hp_rdy_o}, 64'd0);
      chk("rst_np_rdy", {63'd0, np_rdy_o}, 64'd0);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rel_hp_rdy", {63'd0, hp_rdy_o}, 64'd1);
    chk("rel_np_rdy", {63'd0, np_rdy_o}, 64'd0);
    @(posedge clk);
    #1 hp_vld_i = 1'b0;
    @(negedge clk);
    chk("rel_first_vld", {63'd0, vld_o}, 64'd1);
    chk("rel_first_data", {31'd0, data_out}, 64'h1AAAA0001);
    chk("rel_np_rdy2", {63'd0, np_rdy_o}, 64'd1);
    @(posedge clk);
    #1 np_vld_i = 1'b0;
    @(negedge clk);
    chk("rel_np_data", {31'd0, data_out}, 64'h0BBBB0001);
    drain();

    stream(1, 0, 32'hDEADBEEF, 32'd0, 0, 20);
    @(negedge clk);
    chk("single_hp_vld", {63'd0, vld_o}, 64'd1);
    chk("single_hp_data", {31'd0, data_out}, 64'h1DEADBEEF);
    @(posedge clk);
    #1;
    stream(0, 1, 32'd0, 32'h00000005, 0, 20);
    @(negedge clk);
    chk("single_np_vld", {63'd0, vld_o}, 64'd1);
    chk("single_np_data", {31'd0, data_out}, 64'h000000005);
    @(posedge clk);
    #1;
    drain();

    tags.delete();
    np_acc.delete();
    stream(12, 3, 32'h11110000, 32'h22220000, 0, 100);
    drain();
    chk_tags("starve_tag", 15);
    chk("starve_np_n", 64'(np_acc.size()), 64'd3);
    for (int k = 0; k < 3 && k < np_acc.size(); k++)
      chk("starve_np_cyc", 64'(np_acc[k]), 64'(5 * k + 4));

    tags.delete();
    stream(12, 3, 32'h33330000, 32'h44440000, 2, 100);
    drain();
    chk_tags("bp_tag", 15);

    stream(100, 100, 32'h55550000, 32'h66660000, 1, 2000);
    drain();

    stream(1, 0, 32'hCAFE0001, 32'd0, 3, 20);
    @(negedge clk);
    chk("mid_vld", {63'd0, vld_o}, 64'd1);
    chk("mid_data", {31'd0, data_out}, 64'h1CAFE0001);
    #2 rst = 1'b0;
    #1;
    chk("mid_async_vld", {63'd0, vld_o}, 64'd0);
    chk("mid_async_data", {31'd0, data_out}, 64'd0);
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    rdy_i = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("mid_no_replay", {63'd0, vld_o}, 64'd0);
    end
    @(posedge clk);
    #1;

`ifdef PRIO_TAGGER_STATS_EN
    stream(7, 3, 32'h77770000, 32'h88880000, 0, 100);
    drain();
    chk("stats_hp", {48'd0, hp_cnt}, 64'd7);
    chk("stats_np", {48'd0, np_cnt}, 64'd3);
`endif

    chk("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
